// File: rtl/tournament_select.sv
// Population store plus binary-tournament parent selector fed by fitness_eval.
// Tracks the all-time elite and streams POP_SIZE/2 parent pairs per generation.
module tournament_select #(
    parameter int unsigned PARTICLE_LENGTH   = 2,
    parameter int unsigned LATTICE_LENGTH    = 11,
    parameter int unsigned INDIVIDUAL_LENGTH = 22,
    parameter int unsigned SELF_FIT_LENGTH   = 10,
    parameter int unsigned POP_SIZE          = 50,
    parameter int unsigned IDX_WIDTH         = 8,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic                         done_i,
    input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
    input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
    input  logic [IDX_WIDTH-1:0]         ind_wb_idx_i,
    input  logic                         parent_ready_i,
    output logic                         parent_valid_o,
    output logic [INDIVIDUAL_LENGTH-1:0] parent_a_o,
    output logic [INDIVIDUAL_LENGTH-1:0] parent_b_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
    output logic [INDIVIDUAL_LENGTH-1:0] best_vec_o,
    output logic [IDX_WIDTH-1:0]         best_idx_o,
    output logic                         busy_o,
    output logic                         gen_done_o,
    output logic                         drop_err_o
);

    localparam int unsigned Aw       = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
    localparam int unsigned NumPairs = POP_SIZE / 2;
    localparam logic [15:0] Seed     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    if (LATTICE_LENGTH * PARTICLE_LENGTH != INDIVIDUAL_LENGTH) begin : g_len_mismatch
        $error("INDIVIDUAL_LENGTH must equal LATTICE_LENGTH*PARTICLE_LENGTH");
    end

    typedef enum logic [2:0] {StCollect, StSelA, StSelB, StOut, StDone} state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic [IDX_WIDTH-1:0]         pair_cnt_q, pair_cnt_d;
    logic [INDIVIDUAL_LENGTH-1:0] parent_a_q, parent_a_d;
    logic [INDIVIDUAL_LENGTH-1:0] parent_b_q, parent_b_d;
    logic [SELF_FIT_LENGTH-1:0]   best_energy_q, best_energy_d;
    logic [INDIVIDUAL_LENGTH-1:0] best_vec_q, best_vec_d;
    logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic                         drop_err_q, drop_err_d;
    logic [SELF_FIT_LENGTH-1:0]   energy_q [POP_SIZE];
    logic [SELF_FIT_LENGTH-1:0]   energy_d [POP_SIZE];
    logic [INDIVIDUAL_LENGTH-1:0] vec_q    [POP_SIZE];
    logic [INDIVIDUAL_LENGTH-1:0] vec_d    [POP_SIZE];

    logic                         wr_ok;
    logic [Aw-1:0]                wr_idx;
    logic [Aw-1:0]                c0, c1;
    logic [INDIVIDUAL_LENGTH-1:0] win_vec;
    logic                         selecting;

    assign wr_ok  = (state_q == StCollect) && in_valid_i && (32'(ind_wb_idx_i) < POP_SIZE);
    assign wr_idx = Aw'(ind_wb_idx_i);
    assign selecting = (state_q == StSelA) || (state_q == StSelB);

    // Scaled draw: (byte * POP_SIZE) >> 8 always lands inside the population.
    always_comb begin
        c0      = Aw'((16'(lfsr_q[7:0]) * 16'(POP_SIZE)) >> 8);
        c1      = Aw'((16'(lfsr_q[15:8]) * 16'(POP_SIZE)) >> 8);
        win_vec = (energy_q[c1] < energy_q[c0]) ? vec_q[c1] : vec_q[c0];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (done_i) state_d = StSelA;
            StSelA:    state_d = StSelB;
            StSelB:    state_d = StOut;
            StOut: begin
                if (parent_ready_i) begin
                    state_d = (32'(pair_cnt_q) + 32'd1 < NumPairs) ? StSelA : StDone;
                end
            end
            StDone:    state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        energy_d      = energy_q;
        vec_d         = vec_q;
        lfsr_d        = lfsr_q;
        pair_cnt_d    = pair_cnt_q;
        parent_a_d    = parent_a_q;
        parent_b_d    = parent_b_q;
        best_energy_d = best_energy_q;
        best_vec_d    = best_vec_q;
        best_idx_d    = best_idx_q;
        drop_err_d    = drop_err_q;

        if (in_valid_i && !wr_ok) drop_err_d = 1'b1;

        if (wr_ok) begin
            energy_d[wr_idx] = total_energy_i;
            vec_d[wr_idx]    = individual_vec_i;
            if (total_energy_i < best_energy_q) begin
                best_energy_d = total_energy_i;
                best_vec_d    = individual_vec_i;
                best_idx_d    = ind_wb_idx_i;
            end
        end

        if (selecting) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (state_q == StSelA) parent_a_d = win_vec;
        if (state_q == StSelB) parent_b_d = win_vec;
        if (state_q == StOut && parent_ready_i) pair_cnt_d = pair_cnt_q + 1'b1;
        if (state_q == StDone) pair_cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StCollect;
            lfsr_q        <= Seed;
            pair_cnt_q    <= '0;
            parent_a_q    <= '0;
            parent_b_q    <= '0;
            best_energy_q <= '1;
            best_vec_q    <= '0;
            best_idx_q    <= '0;
            drop_err_q    <= 1'b0;
            for (int i = 0; i < POP_SIZE; i++) begin
                energy_q[i] <= '1;
                vec_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            pair_cnt_q    <= pair_cnt_d;
            parent_a_q    <= parent_a_d;
            parent_b_q    <= parent_b_d;
            best_energy_q <= best_energy_d;
            best_vec_q    <= best_vec_d;
            best_idx_q    <= best_idx_d;
            drop_err_q    <= drop_err_d;
            energy_q      <= energy_d;
            vec_q         <= vec_d;
        end
    end

    // Outputs.
    always_comb begin
        parent_valid_o = 1'b0;
        busy_o         = 1'b0;
        gen_done_o     = 1'b0;
        unique case (state_q)
            StSelA, StSelB: busy_o = 1'b1;
            StOut: begin
                busy_o         = 1'b1;
                parent_valid_o = 1'b1;
            end
            StDone:  gen_done_o = 1'b1;
            default: ;
        endcase
        parent_a_o    = parent_a_q;
        parent_b_o    = parent_b_q;
        best_energy_o = best_energy_q;
        best_vec_o    = best_vec_q;
        best_idx_o    = best_idx_q;
        drop_err_o    = drop_err_q;
    end

endmodule

// File: doc/tournament_select.md
# tournament_select

Downstream stage of `fitness_eval`. Captures each evaluated individual (energy, lattice vector, index) into a population store and tracks the all-time elite. On the generation-done strobe it runs POP_SIZE/2 binary-tournament draws and streams parent pairs to the crossover stage over a valid/ready handshake.

## Interface
- `PARTICLE_LENGTH`, default 2: bits per lattice site.
- `LATTICE_LENGTH`, default 11: sites per individual.
- `INDIVIDUAL_LENGTH`, default 22: LATTICE_LENGTH*PARTICLE_LENGTH.
- `SELF_FIT_LENGTH`, default 10: energy width, unsigned.
- `POP_SIZE`, default 50: population size; even, ≤ 2^IDX_WIDTH.
- `IDX_WIDTH`, default 8: index width.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `in_valid_i` input 1: evaluated individual present (from `out_valid_ff_o`).
- `done_i` input 1: generation evaluation finished (from `done_ff_o`).
- `total_energy_i` input SELF_FIT_LENGTH: energy of the individual.
- `individual_vec_i` input INDIVIDUAL_LENGTH: lattice vector.
- `ind_wb_idx_i` input IDX_WIDTH: population slot.
- `parent_ready_i` input 1: consumer accepts the pair.
- `parent_valid_o` output 1: pair valid.
- `parent_a_o` output INDIVIDUAL_LENGTH: first parent.
- `parent_b_o` output INDIVIDUAL_LENGTH: second parent.
- `best_energy_o` output SELF_FIT_LENGTH: elite energy.
- `best_vec_o` output INDIVIDUAL_LENGTH: elite vector.
- `best_idx_o` output IDX_WIDTH: elite slot.
- `busy_o` output 1: high in SELECT or OUT.
- `gen_done_o` output 1: one-cycle pulse after the last pair is accepted.
- `drop_err_o` output 1: sticky; an input was dropped.

## Operation
- Storage:
  - Register arrays `energy[POP_SIZE]`, reset to all-ones (1023).
  - `vec[POP_SIZE]`, reset to 0.
- States are COLLECT (reset state), SELECT_A, SELECT_B, OUT, DONE.
- COLLECT:
  - When `in_valid_i` is high and `ind_wb_idx_i` < POP_SIZE, write the energy and vector to that slot. A repeated index overwrites the slot.
  - When `in_valid_i` is high and `ind_wb_idx_i` ≥ POP_SIZE, drop the write and set `drop_err_o`.
  - Elite update on an accepted write: if `total_energy_i` < `best_energy_o` (strict), load the best_* registers.
  - Elite persists across generations. It clears only on reset and is never retracted on overwrite.
  - If `done_i` is high, go to SELECT_A next cycle. When `in_valid_i` and `done_i` are high in the same cycle, the write is performed first.
- Random draw (once per SELECT cycle):
  - The 16-bit Fibonacci LFSR shifts left.
  - new bit[0] = l[15]^l[13]^l[12]^l[10].
  - c0 = (l[7:0]*POP_SIZE)>>8
  - c1 = (l[15:8]*POP_SIZE)>>8
  - Winner = c1 if energy[c1] < energy[c0], else c0. Ties go to c0.
  - The LFSR advances after the draw.
- SELECT_A: register winner vector into `parent_a_o`, go to SELECT_B.
- SELECT_B: register winner vector into `parent_b_o`, go to OUT.
- OUT:
  - `parent_valid_o` = 1.
  - On `parent_ready_i`, increment the pair counter.
  - If the counter is below POP_SIZE/2, go to SELECT_A; otherwise go to DONE.
- DONE: `gen_done_o` = 1 for one cycle, clear the pair counter, go to COLLECT.
- `in_valid_i` in any state other than COLLECT: input dropped, `drop_err_o` set. `done_i` outside COLLECT is ignored.
- The population store is not cleared between generations.

## Timing
- Reset values:
  - All outputs 0, except `best_energy_o` = all-ones.
  - LFSR = seed, state = COLLECT.
- Reset mid-operation: asynchronous. Outputs go to reset values immediately and any pair in flight is discarded.
- Capture latency: an accepted write is readable by SELECT from the next cycle. best_* update on the edge after the input.
- From `done_i` sampled at edge N: SELECT_A at N+1, first `parent_valid_o` at N+3.
- Handshake:
  - Pair transfers on a cycle with `parent_valid_o` && `parent_ready_i`.
  - Under backpressure, `parent_valid_o` and `parent_*_o` hold stable and the LFSR holds.
  - Next pair is valid 3 cycles after acceptance, so throughput is 1 pair per 3 cycles at full ready.
- Generation length with `parent_ready_i` tied high: 3*POP_SIZE/2 cycles plus 1 DONE cycle (76 cycles at defaults).
- Index math: the 16-bit product is truncated; c0 and c1 are always < POP_SIZE.

## Test plan
- Reset: assert `rst_i` between edges. `parent_valid_o`, `busy_o`, `gen_done_o`, `drop_err_o` = 0 immediately; `best_energy_o` = 1023.
- Full generation:
  - Stimulus: 50 writes, energy = 100+idx, except idx 17 = 5; `done_i` with the last write.
  - Required: `best_energy_o` = 5 and `best_idx_o` = 17.
  - Exactly 25 pairs, the first at done+3 cycles.
  - Each parent must match an LFSR reference model with seed 16'hACE1; `gen_done_o` pulses once.
- Ties: all energies = 200. Every winner equals c0 from the model; `best_idx_o` = 0 (first write).
- Backpressure: hold `parent_ready_i` low 10 cycles on pair 3. Outputs stay stable, and pair 4 equals the model's unstalled sequence.
- Partial generation:
  - Stimulus: `done_i` after 10 writes (idx 0..9, energy 50).
  - Required: any tournament that draws one written and one unwritten slot returns the written slot (50 < 1023).
  - An out-of-range idx 60 write sets `drop_err_o` and leaves the store unchanged.
- Reset mid-SELECT: assert `rst_i` during pair 5. Block returns to COLLECT and `best_energy_o` = 1023; the next generation's first pair equals model pair 1.
